// File: rtl/alu_wb_ctrl_if.sv
// rtl/alu_wb_ctrl_if.sv - instruction handshake, register-file ports and status for alu_wb_ctrl
interface alu_wb_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  r1_addr;
  logic [4:0]  r2_addr;
  logic [31:0] r1_dout;
  logic [31:0] r2_dout;
  logic [4:0]  r3_addr;
  logic [31:0] r3_din;
  logic        r3_wr;
  logic [31:0] result;
  logic        done;
  logic        illegal;
  logic        ovf;

  modport master (
    output instr_valid, instr, r1_dout, r2_dout,
    input  instr_ready, r1_addr, r2_addr, r3_addr, r3_din, r3_wr,
           result, done, illegal, ovf
  );

  modport slave (
    input  instr_valid, instr, r1_dout, r2_dout,
    output instr_ready, r1_addr, r2_addr, r3_addr, r3_din, r3_wr,
           result, done, illegal, ovf
  );
endinterface

// File: rtl/alu_wb_ctrl.sv
// rtl/alu_wb_ctrl.sv - single-issue R-type execute/writeback sequencer
// Walks IDLE -> READ -> EXEC -> WB around a register file with one-cycle read latency.
module alu_wb_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  alu_wb_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [1:0]  state;
  logic [4:0]  q_rd;
  logic [4:0]  q_shamt;
  logic [5:0]  q_funct;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] b_eff;
  logic [31:0] sum;
  logic        is_sub;
  logic        arith_ovf;
  logic [31:0] alu;
  logic        legal;
  logic        unused_opcode;

  assign unused_opcode = ^bus.instr[31:26];

  assign a         = bus.r1_dout;
  assign b         = bus.r2_dout;
  assign is_sub    = (q_funct == F_SUB);
  assign b_eff     = is_sub ? (~b + 32'd1) : b;
  assign sum       = a + b_eff;
  assign arith_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);

  always_comb begin
    alu   = '0;
    legal = 1'b1;
    case (q_funct)
      F_ADD, F_SUB: alu = sum;
      F_AND:        alu = a & b;
      F_OR:         alu = a | b;
      F_XOR:        alu = a ^ b;
      F_NOR:        alu = ~(a | b);
      F_SLT:        alu = {31'd0, $signed(a) < $signed(b)};
      F_SLTU:       alu = {31'd0, a < b};
      F_SLL:        alu = b << q_shamt;
      F_SRL:        alu = b >> q_shamt;
      F_SRA:        alu = $signed(b) >>> q_shamt;
      default:      legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      q_rd            <= '0;
      q_shamt         <= '0;
      q_funct         <= '0;
      bus.instr_ready <= 1'b0;
      bus.r1_addr     <= '0;
      bus.r2_addr     <= '0;
      bus.r3_addr     <= '0;
      bus.r3_din      <= '0;
      bus.r3_wr       <= 1'b0;
      bus.result      <= '0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.ovf         <= 1'b0;
    end else begin
      bus.r3_wr   <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      bus.ovf     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            q_rd            <= bus.instr[15:11];
            q_shamt         <= bus.instr[10:6];
            q_funct         <= bus.instr[5:0];
            bus.r1_addr     <= bus.instr[25:21];
            bus.r2_addr     <= bus.instr[20:16];
            bus.instr_ready <= 1'b0;
            state           <= READ;
          end else begin
            bus.instr_ready <= 1'b1;
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          bus.done    <= 1'b1;
          bus.illegal <= ~legal;
          bus.ovf     <= legal && (q_funct == F_ADD || is_sub) && arith_ovf;
          if (legal) begin
            bus.result <= alu;
            // r0 is architecturally zero, so rd == 0 retires without a write
            if (q_rd != 5'd0) begin
              bus.r3_addr <= q_rd;
              bus.r3_din  <= alu;
              bus.r3_wr   <= 1'b1;
            end
          end
          state <= WB;
        end
        default: begin
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wb_ctrl.sv
// tb/tb_alu_wb_ctrl.sv - scoreboard bench for alu_wb_ctrl with a registered-read register file model
module tb_alu_wb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_wb_ctrl_if bus ();
  alu_wb_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        ill;
    logic        ov;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc[$];
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  // Register file: one-cycle registered reads, write commits on the edge ending WB
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.r1_dout <= rf[bus.r1_addr];
    bus.r2_dout <= rf[bus.r2_addr];
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (bus.r3_wr && bus.r3_addr != 5'd0) rf[bus.r3_addr] <= bus.r3_din;
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("r3_wr", {31'd0, bus.r3_wr}, {31'd0, e.wr});
          if (e.wr) begin
            check("r3_addr", {27'd0, bus.r3_addr}, {27'd0, e.addr});
            check("r3_din", bus.r3_din, e.din);
          end
          check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
          check("ovf", {31'd0, bus.ovf}, {31'd0, e.ov});
          check("result", bus.result, e.res);
        end
      end else if (bus.r3_wr || bus.illegal || bus.ovf) begin
        check("pulse_without_done", 32'd1, 32'd0);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic wr, input logic [31:0] din,
                       input logic ill, input logic ov, input logic [31:0] res);
    exp_t e;
    wait_ready();
    bus.instr = ins; bus.instr_valid = 1'b1;
    e.wr = wr; e.addr = ins[15:11]; e.din = din; e.ill = ill; e.ov = ov; e.res = res;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < target) check("accept_timeout", acc_cnt, target);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_r3_wr", {31'd0, bus.r3_wr}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_r3_din", bus.r3_din, 32'd0);
    check("rst_addrs", {bus.r1_addr, bus.r2_addr, bus.r3_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ready", {31'd0, bus.instr_ready}, 32'd1);

    preload(5'd1, 32'h7FFFFFFF);
    preload(5'd2, 32'h00000001);
    issue(mk(1, 2, 3, 0, 6'h20), 1, 32'h80000000, 0, 1, 32'h80000000);
    drain();
    check("readback_r3", rf[3], 32'h80000000);

    preload(5'd1, 32'hFFFFFFFF);
    preload(5'd10, 32'h80000000);
    preload(5'd12, 32'hF0F0F0F0);
    preload(5'd13, 32'hFF00FF00);
    issue(mk(1, 2, 5, 0, 6'h2A), 1, 32'h00000001, 0, 0, 32'h00000001);
    issue(mk(1, 2, 6, 0, 6'h2B), 1, 32'h00000000, 0, 0, 32'h00000000);
    issue(mk(0, 1, 7, 4, 6'h03), 1, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);
    issue(mk(0, 1, 8, 4, 6'h02), 1, 32'h0FFFFFFF, 0, 0, 32'h0FFFFFFF);
    issue(mk(1, 2, 9, 0, 6'h3F), 0, 32'h0, 1, 0, 32'h0FFFFFFF);
    issue(mk(1, 2, 0, 0, 6'h20), 0, 32'h0, 0, 0, 32'h00000000);
    issue(mk(10, 2, 11, 0, 6'h22), 1, 32'h7FFFFFFF, 0, 1, 32'h7FFFFFFF);
    issue(mk(12, 13, 17, 0, 6'h24), 1, 32'hF000F000, 0, 0, 32'hF000F000);
    issue(mk(12, 13, 18, 0, 6'h25), 1, 32'hFFF0FFF0, 0, 0, 32'hFFF0FFF0);
    issue(mk(12, 13, 19, 0, 6'h26), 1, 32'h0FF00FF0, 0, 0, 32'h0FF00FF0);
    issue(mk(12, 13, 20, 0, 6'h27), 1, 32'h000F000F, 0, 0, 32'h000F000F);
    issue(mk(0, 13, 21, 8, 6'h00), 1, 32'h00FF0000, 0, 0, 32'h00FF0000);
    drain();
    check("rd0_untouched", rf[0], 32'h0);
    check("illegal_no_write", rf[9], 32'h0);

    // Back-to-back with valid held high: ADD into r4, then SUB reading r4
    acc_cyc.delete();
    begin
      int base;
      exp_t e;
      base = acc_cnt;
      @(negedge clk);
      bus.instr = mk(12, 13, 4, 0, 6'h20); bus.instr_valid = 1'b1;
      e.wr = 1; e.addr = 4; e.din = 32'hEFF1EFF0; e.ill = 0; e.ov = 0; e.res = 32'hEFF1EFF0;
      sb.push_back(e);
      wait_acc(base + 1);
      bus.instr = mk(4, 2, 14, 0, 6'h22);
      e.addr = 14; e.din = 32'hEFF1EFEF; e.res = 32'hEFF1EFEF;
      sb.push_back(e);
      wait_acc(base + 2);
      bus.instr_valid = 1'b0;
      drain();
      if (acc_cyc.size() >= 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 32'd4);
      else check("b2b_accepts", acc_cyc.size(), 32'd2);
      check("raw_r14", rf[14], 32'hEFF1EFEF);
    end

    // Reset during EXEC: nothing may be written to r15
    preload(5'd15, 32'h0000AAAA);
    wait_ready();
    bus.instr = mk(12, 2, 15, 0, 6'h20); bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_r3_wr", {31'd0, bus.r3_wr}, 32'd0);
    check("abort_ready", {31'd0, bus.instr_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_r15", rf[15], 32'h0000AAAA);
    check("post_abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    issue(mk(12, 2, 16, 0, 6'h20), 1, 32'hF0F0F0F1, 0, 0, 32'hF0F0F0F1);
    drain();
    check("post_abort_r16", rf[16], 32'hF0F0F0F1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_wb_ctrl.md
# alu_wb_ctrl

Single-issue execute/writeback sequencer that sits directly downstream of the 32x32 register file. It:
- accepts an R-type instruction word through a valid/ready handshake,
- drives the file's two read ports and waits out their one-cycle registered latency,
- performs the ALU operation,
- writes the result back through the file's write port (r3).

One instruction is in flight at a time. A new instruction can be accepted every 4 cycles.

## Interface
- No parameters. Data width is 32 and register address width is 5.
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept; high only in IDLE
- instr  in  32  instruction word: [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct; [31:26] ignored
- r1_addr  out  5  register-file read port 1 address (rs)
- r2_addr  out  5  register-file read port 2 address (rt)
- r1_dout  in  32  register-file read data 1, valid one clock after r1_addr is sampled
- r2_dout  in  32  register-file read data 2, same timing
- r3_addr  out  5  write-back address (rd)
- r3_din  out  32  write-back data
- r3_wr  out  1  write-back enable, one-cycle pulse
- result  out  32  last computed result; held until the next EXEC
- done  out  1  one-cycle pulse when an instruction retires (legal or illegal)
- illegal  out  1  one-cycle pulse with done when funct is unsupported
- ovf  out  1  one-cycle pulse with done on signed overflow of ADD/SUB

## Operation
- All outputs are registered.
- Reset values: every output is 0 (instr_ready = 0 only while rst_n is low), state = IDLE, captured instruction = 0.
- Reset asserted mid-operation aborts immediately:
  - r3_wr drops asynchronously.
  - No write-back occurs.
  - On release, the block returns to IDLE with instr_ready = 1.
- FSM states, in order: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE
  - instr_ready = 1.
  - On instr_valid && instr_ready at an edge: capture instr, load r1_addr = rs and r2_addr = rt, go to READ.
  - instr_valid without ready is ignored; there is no queueing.
- READ
  - No action while the register file samples the addresses.
  - Go to EXEC unconditionally.
- EXEC
  - r1_dout/r2_dout are valid. Compute by funct, with a = r1_dout and b = r2_dout:
    - 0x20 ADD: a+b
    - 0x22 SUB: a-b
    - 0x24 AND
    - 0x25 OR
    - 0x26 XOR
    - 0x27 NOR
    - 0x2A SLT: signed, result 1 or 0
    - 0x2B SLTU: unsigned, result 1 or 0
    - 0x00 SLL: b << shamt
    - 0x02 SRL: b >> shamt, logical
    - 0x03 SRA: b >>> shamt, arithmetic
  - Arithmetic is 32-bit wrap-around. Overflow is never trapped; the write-back still occurs.
  - ovf = (a[31]==b'[31]) && (sum[31]!=a[31]), where b' = b for ADD and ~b+1 for SUB.
  - The result register loads at the EXEC->WB edge.
  - r3_addr = rd, r3_din = result, and r3_wr = 1 are set at that same edge unless funct is illegal or rd == 0.
  - rd == 0 suppresses the write: r0 is held at zero by convention.
  - Illegal funct: no write, result is unchanged, illegal pulses.
- WB
  - r3_wr, done, illegal and ovf are high for exactly this cycle.
  - The register file commits the write at the WB->IDLE edge.
  - r3_addr and r3_din hold their values after WB; only r3_wr is cleared.
- Read-after-write on the next instruction is safe with no bypass: the next accept is at or after the WB->IDLE edge, so its read is sampled at least one edge after the write.

## Timing
- Accept edge T0 -> r1/r2_addr valid in the cycle after T0 -> register file latches dout at T1 -> result/r3_* registered at T2 -> r3_wr and done high during T2..T3 -> write committed at T3.
- instr_ready rises in the cycle after T3. The next accept is at T4 at the earliest, giving throughput of one instruction per 4 cycles.
- r1_addr/r2_addr are held from T0 until the next accept.

## Test plan
- Reset, then idle: with rst_n low, all outputs are 0. After release, instr_ready = 1 and no r3_wr ever appears with instr_valid low.
- ADD with overflow:
  - Stimulus: reg model r1 = 0x7FFFFFFF, r2 = 0x00000001; issue ADD rs=1, rt=2, rd=3.
  - Response: r3_wr pulses at T2..T3 with r3_addr = 3, r3_din = 0x80000000, ovf = 1, done = 1. Readback r3 = 0x80000000.
- SLT vs SLTU with r1 = 0xFFFFFFFF, r2 = 0x00000001:
  - SLT writes 1.
  - SLTU writes 0.
  - SRA r1 by shamt 4 writes 0xFFFFFFFF.
  - SRL r1 by shamt 4 writes 0x0FFFFFFF.
- rd = 0 and illegal funct:
  - ADD with rd = 0: done = 1, r3_wr stays 0.
  - funct = 0x3F: done = 1, illegal = 1, r3_wr = 0, result is unchanged.
- Back-to-back RAW: hold instr_valid high for ADD rd=4 followed by SUB rs=4.
  - Second accept occurs exactly 4 cycles after the first.
  - SUB reads the freshly written r4 value.
- Reset mid-instruction: assert rst_n low during EXEC.
  - r3_wr never pulses and the target register is unchanged.
  - After release, instr_ready = 1 and a new ADD completes normally.
